// File: rtl/conv_sched_pkg.sv
// Shared types and default constants for the conv1d frame sequencer.
package conv_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_START,
        S_WAIT,
        S_CACHE,
        S_DONE
    } sched_state_t;

    localparam int SCHED_N_LAYERS = 4;
    localparam int SCHED_TIMEOUT  = 1023;
    localparam int SCHED_PROF_W   = 16;

    // Width of a layer index; one bit minimum so a single-layer stack still has a port.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of the cache strobe vector; one bit minimum for the same reason.
    function automatic int cache_w(input int n);
        return (n > 1) ? n - 1 : 1;
    endfunction

endpackage

// File: rtl/conv_scheduler_if.sv
// Sequencer-to-layer-stack bundle: sample clock, per-layer valids, strobes and status.
interface conv_scheduler_if
    import conv_sched_pkg::*;
#(
    parameter int N_LAYERS = SCHED_N_LAYERS
) ();

    localparam int LW   = idx_w(N_LAYERS);
    localparam int CS_W = cache_w(N_LAYERS);

    logic                    sample_clk;
    logic [N_LAYERS-1:0]     conv_valid;
    logic                    clear_err;
    logic                    lsb_strobe;
    logic [N_LAYERS-1:0]     conv_start;
    logic [CS_W-1:0]         cache_strobe;
    logic                    out_strobe;
    logic                    busy;
    logic [LW-1:0]           layer_idx;
    logic                    overrun;
    logic                    timeout_err;
    logic [SCHED_PROF_W-1:0] frame_cycles;

    modport master (
        input  sample_clk, conv_valid, clear_err,
        output lsb_strobe, conv_start, cache_strobe, out_strobe,
               busy, layer_idx, overrun, timeout_err, frame_cycles
    );

    modport slave (
        output sample_clk, conv_valid, clear_err,
        input  lsb_strobe, conv_start, cache_strobe, out_strobe,
               busy, layer_idx, overrun, timeout_err, frame_cycles
    );

endinterface

// File: rtl/conv_scheduler_rise_detect.sv
// Rising-edge detector for a level synchronous to clk; shared by sample-clock consumers.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) prev <= 1'b0;
        else      prev <= din;
    end

    assign rise = din & ~prev;

endmodule

// File: rtl/conv_scheduler.sv
// Frame sequencer: shift, then start/wait/cache each conv layer, then strobe the output.
// Optional frame-length profiling is built when SCHED_PROFILE_EN is defined.
module conv_scheduler
    import conv_sched_pkg::*;
#(
    parameter int N_LAYERS = SCHED_N_LAYERS,
    parameter int TIMEOUT  = SCHED_TIMEOUT,
    parameter int CW       = 10
) (
    input  logic             clk,
    input  logic             rst,
    conv_scheduler_if.master bus
);

    localparam int LW   = idx_w(N_LAYERS);
    localparam int CS_W = cache_w(N_LAYERS);
    localparam int PW   = SCHED_PROF_W;
    localparam logic [LW-1:0] LAST_IDX = LW'(N_LAYERS - 1);

    sched_state_t        state;
    logic [LW-1:0]       layer_idx;
    logic [CW-1:0]       wait_cnt;
    logic                edge_det;
    logic                lsb_q;
    logic [N_LAYERS-1:0] start_q;
    logic [CS_W-1:0]     cache_q;
    logic                out_q;
    logic                busy_q;
    logic                overrun_q;
    logic                timeout_q;

    function automatic logic [N_LAYERS-1:0] start_onehot(input logic [LW-1:0] i);
        return N_LAYERS'(1) << i;
    endfunction

    function automatic logic [CS_W-1:0] cache_onehot(input logic [LW-1:0] i);
        return CS_W'(1) << i;
    endfunction

    rise_detect u_rise (
        .clk  (clk),
        .rst  (rst),
        .din  (bus.sample_clk),
        .rise (edge_det)
    );

    // Strobes are driven from the transition into their state, so each lasts exactly one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            layer_idx <= '0;
            wait_cnt  <= '0;
            lsb_q     <= 1'b0;
            start_q   <= '0;
            cache_q   <= '0;
            out_q     <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            lsb_q   <= 1'b0;
            start_q <= '0;
            cache_q <= '0;
            out_q   <= 1'b0;
            if (bus.clear_err) timeout_q <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (edge_det) begin
                        state     <= S_SHIFT;
                        layer_idx <= '0;
                        lsb_q     <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    state   <= S_START;
                    start_q <= start_onehot(layer_idx);
                end
                S_START: begin
                    // Valid is deliberately ignored here so a stale level cannot skip a layer.
                    state    <= S_WAIT;
                    wait_cnt <= '0;
                end
                S_WAIT: begin
                    if (bus.conv_valid[layer_idx]) begin
                        if (layer_idx == LAST_IDX) begin
                            state <= S_DONE;
                            out_q <= 1'b1;
                        end else begin
                            state   <= S_CACHE;
                            cache_q <= cache_onehot(layer_idx);
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                        if (wait_cnt == CW'(TIMEOUT - 1)) begin
                            state     <= S_IDLE;
                            busy_q    <= 1'b0;
                            timeout_q <= 1'b1;
                        end
                    end
                end
                S_CACHE: begin
                    state     <= S_START;
                    layer_idx <= layer_idx + 1'b1;
                    start_q   <= start_onehot(layer_idx + 1'b1);
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Sticky overrun: a set in the same cycle as clear_err wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                               overrun_q <= 1'b0;
        else if (edge_det && state != S_IDLE)   overrun_q <= 1'b1;
        else if (bus.clear_err)                 overrun_q <= 1'b0;
    end

`ifdef SCHED_PROFILE_EN
    logic [PW-1:0] prof_cnt;
    logic [PW-1:0] frame_q;

    function automatic logic [PW-1:0] sat_inc(input logic [PW-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // The latched length includes the DONE cycle itself; aborted frames leave it untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prof_cnt <= '0;
            frame_q  <= '0;
        end else begin
            if (state == S_IDLE && edge_det) prof_cnt <= '0;
            else if (busy_q)                 prof_cnt <= sat_inc(prof_cnt);
            if (state == S_DONE)             frame_q  <= sat_inc(prof_cnt);
        end
    end

    assign bus.frame_cycles = frame_q;
`else
    assign bus.frame_cycles = '0;
`endif

    assign bus.lsb_strobe   = lsb_q;
    assign bus.conv_start   = start_q;
    assign bus.cache_strobe = cache_q;
    assign bus.out_strobe   = out_q;
    assign bus.busy         = busy_q;
    assign bus.layer_idx    = layer_idx;
    assign bus.overrun      = overrun_q;
    assign bus.timeout_err  = timeout_q;

endmodule

// File: tb/tb_conv_scheduler.sv
// Bench for conv_scheduler: per-frame cycle schedules from a latency-driven reference model.
module tb_conv_scheduler;
    import conv_sched_pkg::*;

    localparam int N      = 4;
    localparam int TO     = 8;
    localparam int CWB    = 4;
    localparam int LW     = 2;
    localparam int CSW    = 3;
    localparam int MAXC   = 200;
    localparam int NEVER  = 255;
    localparam int SW     = 1 + N + CSW + 1 + 1 + LW;
    localparam int BUSY_B = LW;
    localparam int OUT_B  = LW + 1;
    localparam int LSB_B  = SW - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    conv_scheduler_if #(.N_LAYERS(N)) bus ();

    conv_scheduler #(.N_LAYERS(N), .TIMEOUT(TO), .CW(CWB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // lat[k]: extra WAIT cycles before layer k's valid appears (0 = valid on first WAIT).
    int             lat [N];
    int             vcnt [N];
    bit             armed [N];
    logic [SW-1:0]  obs  [0:MAXC];
    logic [SW-1:0]  expv [0:MAXC];
    logic           e_lsb  [0:MAXC];
    logic [N-1:0]   e_st   [0:MAXC];
    logic [CSW-1:0] e_ca   [0:MAXC];
    logic           e_out  [0:MAXC];
    logic           e_busy [0:MAXC];
    logic [LW-1:0]  e_idx  [0:MAXC];
    int             exp_len;
    bit             exp_done;
    int             obs_len;
    logic [15:0]    fc_exp = '0;
    logic [15:0]    fc_next;
    logic [SW+17:0] rst_snap;

    // Behavioural conv layers: conv_start resets a layer, valid rises lat[k] WAIT cycles later.
    always @(negedge clk) begin
        if (!rst) begin
            bus.conv_valid = '0;
            for (int k = 0; k < N; k++) armed[k] = 1'b0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (armed[k]) begin
                    if (vcnt[k] == 0) begin
                        bus.conv_valid[k] = 1'b1;
                        armed[k] = 1'b0;
                    end else begin
                        bus.conv_valid[k] = 1'b0;
                        vcnt[k]--;
                    end
                end
                if (bus.conv_start[k]) begin
                    armed[k] = 1'b1;
                    vcnt[k]  = lat[k];
                end
            end
        end
    end

    function automatic logic [SW-1:0] sig();
        return {bus.lsb_strobe, bus.conv_start, bus.cache_strobe, bus.out_strobe,
                bus.busy, bus.layer_idx};
    endfunction

    function automatic int first_diff();
        for (int j = 1; j <= exp_len; j++)
            if (obs[j] !== expv[j]) return j;
        return 0;
    endfunction

    // Cycle j = j-th cycle after the posedge that sees the sample edge.
    task automatic build_model();
        int c;
        int w;
        int last;
        for (int j = 0; j <= MAXC; j++) begin
            e_lsb[j] = 1'b0; e_st[j] = '0; e_ca[j] = '0;
            e_out[j] = 1'b0; e_busy[j] = 1'b0; e_idx[j] = '0;
        end
        e_lsb[1] = 1'b1;
        c = 2; last = 0; exp_done = 1'b0; exp_len = 0;
        for (int k = 0; k < N; k++) begin
            e_st[c][k] = 1'b1;
            last = k;
            if (lat[k] >= TO) begin
                for (int j = c; j <= c + TO; j++) e_idx[j] = LW'(k);
                exp_len = c + TO + 1;
                break;
            end
            w = c + 1 + lat[k];
            for (int j = c; j <= w + 1; j++) e_idx[j] = LW'(k);
            if (k < N - 1) begin
                e_ca[w + 1][k] = 1'b1;
                c = w + 2;
            end else begin
                e_out[w + 1] = 1'b1;
                exp_len = w + 2;
                exp_done = 1'b1;
            end
        end
        for (int j = 1; j < exp_len; j++) e_busy[j] = 1'b1;
        for (int j = exp_len; j <= MAXC; j++) e_idx[j] = LW'(last);
        for (int j = 0; j <= MAXC; j++)
            expv[j] = {e_lsb[j], e_st[j], e_ca[j], e_out[j], e_busy[j], e_idx[j]};
`ifdef SCHED_PROFILE_EN
        fc_next = exp_done ? 16'(exp_len - 1) : fc_exp;
`else
        fc_next = 16'd0;
`endif
    endtask

    task automatic run_frame(input int ovr_at, input int clr_at, input int rst_at);
        for (int j = 0; j <= MAXC; j++) obs[j] = 'x;
        obs_len = -1;
        bus.sample_clk = 1'b1;
        for (int j = 1; j <= MAXC; j++) begin
            @(negedge clk);
            obs[j] = sig();
            bus.clear_err = (j == clr_at);
            if (j == 1 || j == ovr_at + 1) bus.sample_clk = 1'b0;
            if (j == ovr_at) bus.sample_clk = 1'b1;
            if (j == rst_at) begin
                #2 rst = 1'b0;
                #1 rst_snap = {sig(), bus.overrun, bus.timeout_err, bus.frame_cycles};
                obs_len = j;
                break;
            end
            if (!bus.busy) begin
                obs_len = j;
                break;
            end
        end
        bus.clear_err = 1'b0;
        if (rst_at == 0) fc_exp = fc_next;
    endtask

    task automatic test_reset();
        bus.sample_clk = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if ({sig(), bus.overrun, bus.timeout_err, bus.frame_cycles} !== '0) begin
            n_bad++;
            $display("FAIL reset_state: got %h required 0",
                     {sig(), bus.overrun, bus.timeout_err, bus.frame_cycles});
        end
        bus.sample_clk = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_zero_latency();
        int fd;
        lat = '{0, 0, 0, 0};
        build_model();
        run_frame(0, 0, 0);
        n_cmp++;
        if (obs_len !== exp_len) begin
            n_bad++;
            $display("FAIL zero_lat_len: got %0d required %0d", obs_len, exp_len);
        end
        n_cmp++;
        fd = first_diff();
        if (fd != 0) begin
            n_bad++;
            $display("FAIL zero_lat_seq: cycle %0d got %h required %h", fd, obs[fd], expv[fd]);
        end
        n_cmp++;
        if (obs[13][OUT_B] !== 1'b1 || obs[1][LSB_B] !== 1'b1) begin
            n_bad++;
            $display("FAIL zero_lat_out13: got out=%b lsb=%b required 1 1", obs[13][OUT_B], obs[1][LSB_B]);
        end
        n_cmp++;
        if (bus.frame_cycles !== fc_exp) begin
            n_bad++;
            $display("FAIL zero_lat_fc: got %0d required %0d", bus.frame_cycles, fc_exp);
        end
    endtask

    task automatic test_fixed_latency();
        int fd;
        lat = '{4, 4, 4, 4};
        build_model();
        run_frame(0, 0, 0);
        n_cmp++;
        fd = first_diff();
        if (fd != 0 || obs_len !== exp_len) begin
            n_bad++;
            $display("FAIL lat4_seq: cycle %0d got %h required %h len %0d/%0d",
                     fd, obs[fd], expv[fd], obs_len, exp_len);
        end
        n_cmp++;
        if (obs[29][OUT_B] !== 1'b1) begin
            n_bad++;
            $display("FAIL lat4_out29: got %b required 1", obs[29][OUT_B]);
        end
        n_cmp++;
        if (bus.frame_cycles !== fc_exp) begin
            n_bad++;
            $display("FAIL lat4_fc: got %0d required %0d", bus.frame_cycles, fc_exp);
        end
    endtask

    task automatic test_timeout();
        int fd;
        lat = '{0, NEVER, 0, 0};
        build_model();
        run_frame(0, 0, 0);
        n_cmp++;
        fd = first_diff();
        if (fd != 0 || obs_len !== exp_len) begin
            n_bad++;
            $display("FAIL timeout_seq: cycle %0d got %h required %h len %0d/%0d",
                     fd, obs[fd], expv[fd], obs_len, exp_len);
        end
        n_cmp++;
        if (obs[13][BUSY_B] !== 1'b1 || obs[14][BUSY_B] !== 1'b0 || bus.timeout_err !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_abort: got busy13=%b busy14=%b err=%b required 1 0 1",
                     obs[13][BUSY_B], obs[14][BUSY_B], bus.timeout_err);
        end
        n_cmp++;
        if (bus.frame_cycles !== fc_exp) begin
            n_bad++;
            $display("FAIL timeout_fc: got %0d required %0d", bus.frame_cycles, fc_exp);
        end
        for (int k = 0; k < N; k++) lat[k] = $urandom_range(0, 3);
        build_model();
        run_frame(0, 0, 0);
        n_cmp++;
        fd = first_diff();
        if (fd != 0 || bus.timeout_err !== 1'b1) begin
            n_bad++;
            $display("FAIL after_timeout_frame: cycle %0d got %h required %h err %b",
                     fd, obs[fd], expv[fd], bus.timeout_err);
        end
        bus.clear_err = 1'b1;
        @(negedge clk);
        bus.clear_err = 1'b0;
        n_cmp++;
        if (bus.timeout_err !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_clear: got %b required 0", bus.timeout_err);
        end
    endtask

    task automatic test_overrun();
        int fd;
        for (int k = 0; k < N; k++) lat[k] = $urandom_range(0, 5);
        build_model();
        run_frame(3, 0, 0);
        n_cmp++;
        fd = first_diff();
        if (fd != 0 || obs_len !== exp_len) begin
            n_bad++;
            $display("FAIL overrun_seq: cycle %0d got %h required %h len %0d/%0d",
                     fd, obs[fd], expv[fd], obs_len, exp_len);
        end
        n_cmp++;
        if (bus.overrun !== 1'b1 || obs[4][LSB_B] !== 1'b0) begin
            n_bad++;
            $display("FAIL overrun_set: got %b required 1", bus.overrun);
        end
        bus.clear_err = 1'b1;
        @(negedge clk);
        bus.clear_err = 1'b0;
        n_cmp++;
        if (bus.overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL overrun_clear: got %b required 0", bus.overrun);
        end
        build_model();
        run_frame(4, 4, 0);
        n_cmp++;
        if (bus.overrun !== 1'b1) begin
            n_bad++;
            $display("FAIL overrun_set_wins: got %b required 1", bus.overrun);
        end
        bus.clear_err = 1'b1;
        @(negedge clk);
        bus.clear_err = 1'b0;
    endtask

    task automatic test_random();
        int fd;
        for (int f = 0; f < 10; f++) begin
            for (int k = 0; k < N; k++)
                lat[k] = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(0, 6));
            build_model();
            run_frame(0, 0, 0);
            n_cmp++;
            fd = first_diff();
            if (fd != 0 || obs_len !== exp_len || bus.frame_cycles !== fc_exp) begin
                n_bad++;
                $display("FAIL random_frame%0d: cycle %0d got %h required %h len %0d/%0d fc %0d/%0d",
                         f, fd, obs[fd], expv[fd], obs_len, exp_len, bus.frame_cycles, fc_exp);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        bus.clear_err = 1'b1;
        @(negedge clk);
        bus.clear_err = 1'b0;
    endtask

    task automatic test_back_to_back();
        int fd;
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < N; k++) lat[k] = $urandom_range(0, 2);
            build_model();
            run_frame(0, 0, 0);
            n_cmp++;
            fd = first_diff();
            if (fd != 0 || obs_len !== exp_len || bus.overrun !== 1'b0) begin
                n_bad++;
                $display("FAIL back_to_back%0d: cycle %0d got %h required %h overrun %b",
                         f, fd, obs[fd], expv[fd], bus.overrun);
            end
        end
    endtask

    task automatic test_reset_midframe();
        int fd;
        // Layer 2 starts at cycle 11 and waits through cycles 12..16.
        lat = '{1, 2, 5, 0};
        build_model();
        run_frame(3, 0, 13);
        n_cmp++;
        if (rst_snap !== '0 || obs[13] !== expv[13]) begin
            n_bad++;
            $display("FAIL reset_midframe: got %h required 0 (pre %h/%h)", rst_snap, obs[13], expv[13]);
        end
        fc_exp = '0;
        bus.sample_clk = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        lat = '{0, 0, 0, 0};
        build_model();
        run_frame(0, 0, 0);
        n_cmp++;
        fd = first_diff();
        if (fd != 0 || obs_len !== exp_len || bus.frame_cycles !== fc_exp) begin
            n_bad++;
            $display("FAIL after_reset_frame: cycle %0d got %h required %h fc %0d/%0d",
                     fd, obs[fd], expv[fd], bus.frame_cycles, fc_exp);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.sample_clk = 1'b0;
        bus.clear_err  = 1'b0;
        bus.conv_valid = '0;
        test_reset();
        test_zero_latency();
        test_fixed_latency();
        test_timeout();
        test_overrun();
        test_random();
        test_back_to_back();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
